moving_average: RTL and testbench
=================================

Name: moving_average

Overview:
- Streaming boxcar (moving-average) filter on an unsigned sample stream.
- Samples one input word every clock.
- Outputs the truncated mean of the most recent 2^WINDOW_LOG2 samples as a registered value.
- Sits between the HEATWATCH sensor front end and the threshold/display logic to smooth noisy readings.

Parameters:
- DATA_WIDTH, 11: width of input samples and of the averaged result.
- WINDOW_LOG2, 2: log2 of window length; window N = 2^WINDOW_LOG2 (default 4 samples). Legal range 1..6.

Ports:
- clk, input, 1: single system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- data_input, input, DATA_WIDTH: unsigned sample, captured on every rising clk edge while reset is low.
- result_output, output, DATA_WIDTH: registered unsigned moving average.

Behaviour:
- Reset (asynchronous, active-high):
  - While reset=1, all of the following are forced to 0 immediately, independent of clk: the N-entry sample history, the running sum, the write pointer, and result_output.
  - Reset asserted mid-stream discards all history. After release, the filter restarts exactly as from power-up.
- Sample capture:
  - On each rising edge with reset=0, data_input is written into the history slot addressed by the write pointer, replacing the oldest sample.
  - The write pointer is a WINDOW_LOG2-bit circular index (0..N-1) and increments modulo N (wraps N-1 -> 0).
- Running sum:
  - Width is DATA_WIDTH+WINDOW_LOG2 bits; this can never overflow.
  - Update per edge: sum_next = sum + data_input - history[wr_ptr], where history[wr_ptr] is the value being overwritten.
  - The sum is not recomputed from the whole buffer.
- Output:
  - On the same edge, result_output <= sum_next >> WINDOW_LOG2, i.e. floor division by N with no rounding.
  - The result always fits in DATA_WIDTH bits.
  - Latency is one clock: the average that includes a sample is visible after the edge that captured it.
- Warm-up:
  - No valid flag.
  - During the first N-1 samples after reset, unfilled slots contribute 0, so the output ramps up. This is required behaviour, not an error.
- Steady input:
  - A constant input value V produces result_output = V from the N-th edge after reset release onward.
- Maximum input:
  - All-ones input sustained for N edges gives result_output = 2^DATA_WIDTH-1 (2047 at defaults), with no wrap.
- Fully synchronous datapath otherwise; no combinational path from data_input to result_output.

Test Plan:
1. Reset: hold reset=1 for 3 cycles with data_input=5 -> result_output=0 throughout. Deassert with data_input=0 -> result_output stays 0.
2. Ramp (defaults, N=4): after reset, apply 1 for 3 edges, then 2 for 3 edges.
   - Outputs after edges 1,2,3 = 0,0,0 (sums 1,2,3).
   - Outputs after edges 4,5,6 = 1,1,1 (sums 5,6,7).
   - One more edge of 2 -> sum 8, output 2.
3. Steady state and truncation:
   - Constant 100 for 6 edges -> outputs 25,50,75,100,100,100.
   - Then window {100,100,100,101} -> output 100 (floor of 100.25).
4. Maximum value: 2047 for 4 edges -> outputs 511,1023,1535,2047. Then 0 for 4 edges -> 1535,1023,511,0.
5. Wrap-around: feed 1,2,3,4,5,6,7,8 -> outputs 0,0,1,2,3,4,5,6. This confirms the oldest sample is evicted after pointer wrap.
6. Mid-stream reset: after step 3 steady state, pulse reset asynchronously between edges.
   - result_output -> 0 immediately.
   - Next input 8 -> output 2, proving the history was cleared.

Source files
------------

// File: rtl/moving_average_if.sv
// rtl/moving_average_if.sv - sample/result bundle between sensor front end and the boxcar filter
interface moving_average_if #(
  parameter int DATA_WIDTH = 11
);
  logic [DATA_WIDTH-1:0] data_input;
  logic [DATA_WIDTH-1:0] result_output;

  modport master (
    output data_input,
    input  result_output
  );

  modport slave (
    input  data_input,
    output result_output
  );
endinterface

// File: rtl/moving_average.sv
// rtl/moving_average.sv - boxcar filter, registered truncated mean of the last 2^WINDOW_LOG2 samples
module moving_average #(
  parameter int DATA_WIDTH  = 11,
  parameter int WINDOW_LOG2 = 2
) (
  input  logic            clk,
  input  logic            reset,
  moving_average_if.slave bus
);
  localparam int N  = 1 << WINDOW_LOG2;
  localparam int SW = DATA_WIDTH + WINDOW_LOG2;

  logic [DATA_WIDTH-1:0]  hist_q [N];
  logic [WINDOW_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [SW-1:0]          sum_q, sum_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic [SW-1:0]          new_ext, old_ext;

  // The slot under wr_ptr holds the oldest sample; it leaves the window as the new one enters.
  always_comb begin
    new_ext  = {{WINDOW_LOG2{1'b0}}, bus.data_input};
    old_ext  = {{WINDOW_LOG2{1'b0}}, hist_q[wr_ptr_q]};
    sum_d    = sum_q + new_ext - old_ext;
    result_d = sum_d[SW-1:WINDOW_LOG2];
    wr_ptr_d = wr_ptr_q + WINDOW_LOG2'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        hist_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      sum_q    <= '0;
      result_q <= '0;
    end else begin
      hist_q[wr_ptr_q] <= bus.data_input;
      wr_ptr_q         <= wr_ptr_d;
      sum_q            <= sum_d;
      result_q         <= result_d;
    end
  end

  assign bus.result_output = result_q;
endmodule

// File: tb/tb_moving_average.sv
// tb/tb_moving_average.sv - directed vectors against hand-computed averages
module tb_moving_average;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  moving_average_if #(.DATA_WIDTH(11)) bus ();

  moving_average #(.DATA_WIDTH(11), .WINDOW_LOG2(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [10:0] got, input int exp);
    vectors++;
    if (got !== 11'(exp)) begin
      miscompares++;
      $display("FAIL %s: result_output=%0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one sample, let one edge capture it, then sample the output 1 time unit later.
  task automatic step(input string tag, input int val, input int exp);
    bus.data_input = 11'(val);
    @(posedge clk);
    #1;
    check_eq(tag, bus.result_output, exp);
  endtask

  // Asynchronous pulse placed between edges; output must clear without a clock edge.
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    check_eq(tag, bus.result_output, 0);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    bus.data_input = 11'd5;
    #1;
    check_eq("reset_t0", bus.result_output, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("reset_hold", bus.result_output, 0);
    end
    reset = 1'b0;
    step("post_reset0", 0, 0);
    step("post_reset1", 0, 0);

    pulse_reset("ramp_rst");
    step("ramp1", 1, 0);
    step("ramp2", 1, 0);
    step("ramp3", 1, 0);
    step("ramp4", 2, 1);
    step("ramp5", 2, 1);
    step("ramp6", 2, 1);
    step("ramp7", 2, 2);

    pulse_reset("steady_rst");
    step("steady1", 100, 25);
    step("steady2", 100, 50);
    step("steady3", 100, 75);
    step("steady4", 100, 100);
    step("steady5", 100, 100);
    step("steady6", 100, 100);
    step("trunc", 101, 100);

    pulse_reset("midstream_rst");
    step("after_rst", 8, 2);
    bus.data_input = 11'd2047;
    #3;
    check_eq("no_comb_path", bus.result_output, 2);

    pulse_reset("max_rst");
    step("max1", 2047, 511);
    step("max2", 2047, 1023);
    step("max3", 2047, 1535);
    step("max4", 2047, 2047);
    step("drain1", 0, 1535);
    step("drain2", 0, 1023);
    step("drain3", 0, 511);
    step("drain4", 0, 0);

    pulse_reset("wrap_rst");
    step("wrap1", 1, 0);
    step("wrap2", 2, 0);
    step("wrap3", 3, 1);
    step("wrap4", 4, 2);
    step("wrap5", 5, 3);
    step("wrap6", 6, 4);
    step("wrap7", 7, 5);
    step("wrap8", 8, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
